// File: rtl/row_weight_loader_if.sv
// Weight stream (valid/ready) plus row-storage write port for row_weight_loader.
// The loader takes the slave side; whatever feeds weights and observes writes takes master.
interface row_weight_loader_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [WEIGHT_WIDTH-1:0]               in_data;
  logic                                  wr_en;
  logic [ADDR_WIDTH-1:0]                 wr_addr;
  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/row_weight_loader.sv
// Packs a serial weight stream into SYSTOLIC_SIZE-wide rows and writes one row
// per completed group to the row weight storage; a full load is SYSTOLIC_SIZE rows.
module row_weight_loader #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  row_weight_loader_if.slave  bus
);

  localparam int ROW_W = SYSTOLIC_SIZE * WEIGHT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d;
  logic [ADDR_WIDTH-1:0]   row_q, row_d;
  logic [ROW_W-1:0]        pack_q, pack_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ROW_W-1:0]        wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    hs;

  assign hs = bus.in_valid && (state_q == LOAD);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    pack_d    = pack_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          col_d   = '0;
          row_d   = '0;
          pack_d  = '0;
        end
      end
      LOAD: begin
        // abort outranks a same-cycle handshake, so a completing row is dropped too
        if (abort) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
          pack_d  = '0;
        end else if (hs) begin
          pack_d[int'(col_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bus.in_data;
          if (col_q == LAST) begin
            col_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = row_q;
            wr_data_d = pack_d;
            if (row_q == LAST) begin
              state_d = IDLE;
              row_d   = '0;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + ADDR_WIDTH'(1);
            end
          end else begin
            col_d = col_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = (state_q == LOAD);
  assign busy         = (state_q == LOAD);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign done         = done_q;

endmodule

// File: tb/tb_row_weight_loader.sv
// Bench for row_weight_loader: a stream model pushes expected row writes into a
// scoreboard as weights are accepted; a negedge monitor pops and compares them.
module tb_row_weight_loader;

  localparam int N = 8;
  localparam int W = 8;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;

  row_weight_loader_if #(.SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(W)) bus ();

  row_weight_loader #(.SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] data;
    logic        last;
  } wr_t;

  wr_t         sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_cyc = 0;
  int          wr_cyc_q[$];
  logic [63:0] last_data [N];
  logic        prev_wr = 1'b0;

  // stream model
  bit          m_load = 1'b0;
  int          m_col = 0;
  int          m_row = 0;
  logic [63:0] m_pack = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.wr_en) begin
        check("wr_back_to_back", 64'(prev_wr), 64'(0));
        check("wr_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
          check("wr_data", bus.wr_data, e.data);
          check("wr_done", 64'(done), 64'(e.last));
        end
        last_data[bus.wr_addr] = bus.wr_data;
        wr_cyc_q.push_back(cyc);
        wr_cnt++;
      end
      if (done) begin
        check("done_with_wr", 64'(bus.wr_en), 64'(1));
        done_cnt++;
        done_cyc = cyc;
      end
      prev_wr = bus.wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic model_clear();
    m_col  = 0;
    m_row  = 0;
    m_pack = '0;
  endtask

  // Applies one cycle of inputs, steps the model, and advances to just after the edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic st,
                       input logic ab, output logic hs);
    bus.in_valid = v;
    bus.in_data  = d;
    start        = st;
    abort        = ab;
    check("in_ready", 64'(bus.in_ready), 64'(m_load));
    check("busy", 64'(busy), 64'(m_load));
    hs = 1'b0;
    if (!m_load) begin
      if (st && !ab) begin
        m_load = 1'b1;
        model_clear();
      end
    end else if (ab) begin
      m_load = 1'b0;
      model_clear();
    end else if (v) begin
      hs = 1'b1;
      m_pack[m_col*8 +: 8] = d;
      if (m_col == N-1) begin
        sb.push_back('{addr: 3'(m_row), data: m_pack, last: (m_row == N-1)});
        m_col = 0;
        if (m_row == N-1) begin
          m_load = 1'b0;
          m_row  = 0;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, hs);
  endtask

  // Starts a load and feeds `count` weights (value = running index = row*8+col).
  task automatic feed(input int count, input bit gaps, input bit restart_mid);
    logic hs;
    logic v;
    int   guard;
    drive(1'b0, 8'h00, 1'b1, 1'b0, hs);
    for (int idx = 0; idx < count; idx++) begin
      guard = 0;
      do begin
        v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (idx == 0) first_cyc = cyc;
        drive(v, 8'(idx), restart_mid && (idx == 2*N + 3), 1'b0, hs);
        guard++;
      end while (!hs && guard < 200);
      check("hs_timeout", 64'(hs), 64'(1));
    end
  endtask

  initial begin
    int wr0;
    int dn0;
    logic hs;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_en", 64'(bus.wr_en), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    check("rst_wr_data", bus.wr_data, 64'(0));
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // data presented while idle must be ignored
    wr0 = wr_cnt;
    drive(1'b1, 8'hAA, 1'b0, 1'b0, hs);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, hs);
    idle(1);
    check("idle_no_wr", 64'(wr_cnt - wr0), 64'(0));

    // gap-free full load
    wr0 = wr_cnt;
    dn0 = done_cnt;
    wr_cyc_q.delete();
    feed(N*N, 1'b0, 1'b0);
    idle(2);
    check("a_sb_empty", 64'(sb.size()), 64'(0));
    check("a_writes", 64'(wr_cnt - wr0), 64'(N));
    check("a_done_cnt", 64'(done_cnt - dn0), 64'(1));
    // handshake cycles plus the done cycle, counted inclusively
    check("a_done_latency", 64'(done_cyc - first_cyc + 1), 64'(65));
    check("a_row0", last_data[0], 64'h0706050403020100);
    check("a_row7", last_data[7], 64'h3F3E3D3C3B3A3938);
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check("a_wr_spacing", 64'(wr_cyc_q[i] - wr_cyc_q[i-1]), 64'(N));

    // random stalls, plus a start pulse mid row 2 that must be ignored
    wr0 = wr_cnt;
    dn0 = done_cnt;
    feed(N*N, 1'b1, 1'b1);
    idle(2);
    check("b_sb_empty", 64'(sb.size()), 64'(0));
    check("b_writes", 64'(wr_cnt - wr0), 64'(N));
    check("b_done_cnt", 64'(done_cnt - dn0), 64'(1));
    check("b_row7", last_data[7], 64'h3F3E3D3C3B3A3938);

    // abort after 3 weights of row 3
    wr0 = wr_cnt;
    dn0 = done_cnt;
    feed(3*N + 3, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, hs);
    check("abort_busy", 64'(busy), 64'(0));
    idle(3);
    check("abort_writes", 64'(wr_cnt - wr0), 64'(3));
    check("abort_no_done", 64'(done_cnt - dn0), 64'(0));
    check("abort_sb_empty", 64'(sb.size()), 64'(0));
    wr0 = wr_cnt;
    feed(N*N, 1'b0, 1'b0);
    idle(2);
    check("reload_writes", 64'(wr_cnt - wr0), 64'(N));
    check("reload_sb_empty", 64'(sb.size()), 64'(0));

    // abort on the completing handshake of row 1
    wr0 = wr_cnt;
    feed(2*N - 1, 1'b0, 1'b0);
    drive(1'b1, 8'(2*N - 1), 1'b0, 1'b1, hs);
    check("abort_row_busy", 64'(busy), 64'(0));
    idle(3);
    check("abort_row_writes", 64'(wr_cnt - wr0), 64'(1));

    // asynchronous reset during row 4
    feed(4*N + 3, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_wr_en", 64'(bus.wr_en), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    check("mid_rst_wr_data", bus.wr_data, 64'(0));
    m_load = 1'b0;
    model_clear();
    sb.delete();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    feed(N*N, 1'b0, 1'b0);
    idle(2);
    check("post_rst_writes", 64'(wr_cnt - wr0), 64'(N));
    check("post_rst_done", 64'(done_cnt - dn0), 64'(1));
    check("post_rst_sb_empty", 64'(sb.size()), 64'(0));
    check("post_rst_row0", last_data[0], 64'h0706050403020100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
